// File: rtl/cm_pkg.sv
// Shared types and sizing helpers for the select-mux capture block.
package cm_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } cm_cap_state_e;

  function automatic int sel_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/cm_settle_cnt.sv
// Settle-time down-counter: loads a count, decrements on request, flags zero.
module cm_settle_cnt
  import cm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cm_demux_capture.sv
// Drives a 16:1-style mux select, samples its output once per code and
// reassembles the bits into a parallel word on a valid/ready handshake.
module cm_demux_capture
  import cm_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 0,
  parameter bit INVERT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      line_i,
  output logic [sel_w(WIDTH)-1:0]   sel_o,
  output logic                      en_n_o,
  output logic [WIDTH-1:0]          word_o,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      busy
);

  localparam int SEL_W = sel_w(WIDTH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
  // Counter is loaded with SETTLE-1 so SETTLE cycles pass before SAMPLE.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;

  cm_cap_state_e    state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_n_q, en_n_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic sweep_go;
  logic enter_code;
  logic sample_bit;

  assign sample_bit = line_i ^ INVERT;

  cm_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    en_n_d     = en_n_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    valid_d    = valid_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    sweep_go   = 1'b0;
    enter_code = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          sweep_go = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          en_n_d   = 1'b1;
          sel_d    = '0;
          shadow_d = '0;
        end else if (cnt_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          en_n_d   = 1'b1;
          sel_d    = '0;
          shadow_d = '0;
        end else begin
          shadow_d[sel_q] = sample_bit;
          if (sel_q == SEL_LAST) begin
            // The last bit is merged straight from the line, not via shadow_q.
            word_d  = shadow_d;
            valid_d = 1'b1;
            en_n_d  = 1'b1;
            sel_d   = '0;
            state_d = ST_DONE;
          end else begin
            sel_d      = sel_q + SEL_W'(1);
            enter_code = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (word_ready) begin
          valid_d = 1'b0;
          if (start) begin
            sweep_go = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sweep_go) begin
      sel_d      = '0;
      en_n_d     = 1'b0;
      enter_code = 1'b1;
    end

    if (enter_code) begin
      if (SETTLE > 0) begin
        state_d  = ST_SETTLE;
        cnt_load = 1'b1;
      end else begin
        state_d = ST_SAMPLE;
      end
    end
  end

  // NOTE: the shadow and output words are reset explicitly so a reset mid-sweep
  // can never expose stale or partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      en_n_q   <= 1'b1;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      en_n_q   <= en_n_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  assign sel_o      = sel_q;
  assign en_n_o     = en_n_q;
  assign word_o     = word_q;
  assign word_valid = valid_q;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

endmodule

// File: tb/tb_cm_demux_capture.sv
// Directed bench for cm_demux_capture: three instances cover SETTLE=0, SETTLE=3 and INVERT=1.
module tb_cm_demux_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: SETTLE=0, INVERT=0
  logic        start_a, abort_a, ready_a, line_a, en_n_a, valid_a, busy_a;
  logic [3:0]  sel_a;
  logic [15:0] word_a, pat_a;
  assign line_a = pat_a[sel_a];

  // Instance B: SETTLE=3
  logic        start_b, abort_b, ready_b, line_b, en_n_b, valid_b, busy_b;
  logic [3:0]  sel_b;
  logic [15:0] word_b, pat_b;
  assign line_b = pat_b[sel_b];

  // Instance C: INVERT=1, the mux output line is inverted
  logic        start_c, abort_c, ready_c, line_c, en_n_c, valid_c, busy_c;
  logic [3:0]  sel_c;
  logic [15:0] word_c, pat_c;
  assign line_c = ~pat_c[sel_c];

  cm_demux_capture #(.WIDTH(16), .SETTLE(0), .INVERT(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .line_i(line_a),
    .sel_o(sel_a), .en_n_o(en_n_a), .word_o(word_a), .word_valid(valid_a),
    .word_ready(ready_a), .busy(busy_a));

  cm_demux_capture #(.WIDTH(16), .SETTLE(3), .INVERT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .line_i(line_b),
    .sel_o(sel_b), .en_n_o(en_n_b), .word_o(word_b), .word_valid(valid_b),
    .word_ready(ready_b), .busy(busy_b));

  cm_demux_capture #(.WIDTH(16), .SETTLE(0), .INVERT(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .line_i(line_c),
    .sel_o(sel_c), .en_n_o(en_n_c), .word_o(word_c), .word_valid(valid_c),
    .word_ready(ready_c), .busy(busy_c));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs instance A from the accepting edge until word_valid, checking the select walk.
  task automatic run_a(input string tag, input logic [15:0] exp_word);
    int k;
    int seq_err;
    k = 0;
    seq_err = 0;
    while (!valid_a && k < 200) begin
      if (sel_a !== 4'(k) || en_n_a !== 1'b0 || busy_a !== 1'b1) seq_err++;
      cyc();
      k++;
    end
    n_checks++; if (seq_err !== 0) $display("FAIL %s_sel_walk: %0d bad cycles, need 0", tag, seq_err); else n_pass++;
    n_checks++; if (k !== 16) $display("FAIL %s_latency: valid after %0d cycles, need 16", tag, k); else n_pass++;
    n_checks++; if (word_a !== exp_word) $display("FAIL %s_word: got %h need %h", tag, word_a, exp_word); else n_pass++;
    n_checks++; if (en_n_a !== 1'b1 || busy_a !== 1'b0 || sel_a !== 4'd0)
      $display("FAIL %s_done_outputs: en_n=%b busy=%b sel=%0d need 1 0 0", tag, en_n_a, busy_a, sel_a); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {start_a, abort_a, ready_a} = '0;
    {start_b, abort_b, ready_b} = '0;
    {start_c, abort_c, ready_c} = '0;
    pat_a = '0; pat_b = '0; pat_c = '0;
    repeat (3) cyc();
    n_checks++; if (sel_a !== 4'd0) $display("FAIL reset_sel: got %0d need 0", sel_a); else n_pass++;
    n_checks++; if (en_n_a !== 1'b1) $display("FAIL reset_en_n: got %b need 1", en_n_a); else n_pass++;
    n_checks++; if (word_a !== 16'h0) $display("FAIL reset_word: got %h need 0000", word_a); else n_pass++;
    n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL reset_valid_busy: got %b%b need 00", valid_a, busy_a); else n_pass++;
    rst_n = 1'b1;
    repeat (2) cyc();
    n_checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || en_n_c !== 1'b1) $display("FAIL idle_after_reset: busy_a=%b busy_b=%b en_n_c=%b", busy_a, busy_b, en_n_c); else n_pass++;
  endtask

  task automatic test_basic();
    pat_a = 16'hA5C3;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_a("basic", 16'hA5C3);
  endtask

  task automatic test_settle();
    int k;
    int seq_err;
    pat_b = 16'h0001;
    start_b = 1'b1; cyc(); start_b = 1'b0;
    k = 0;
    seq_err = 0;
    while (!valid_b && k < 300) begin
      if (sel_b !== 4'(k / 4) || en_n_b !== 1'b0) seq_err++;
      cyc();
      k++;
    end
    n_checks++; if (seq_err !== 0) $display("FAIL settle_hold: %0d bad cycles, need 0", seq_err); else n_pass++;
    n_checks++; if (k !== 64) $display("FAIL settle_latency: valid after %0d cycles, need 64", k); else n_pass++;
    n_checks++; if (word_b !== 16'h0001) $display("FAIL settle_word: got %h need 0001", word_b); else n_pass++;
  endtask

  task automatic test_invert();
    int k;
    pat_c = 16'h1234;
    start_c = 1'b1; cyc(); start_c = 1'b0;
    k = 0;
    while (!valid_c && k < 200) begin cyc(); k++; end
    n_checks++; if (k !== 16) $display("FAIL invert_latency: valid after %0d cycles, need 16", k); else n_pass++;
    n_checks++; if (word_c !== 16'h1234) $display("FAIL invert_word: got %h need 1234", word_c); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int hold_err;
    hold_err = 0;
    pat_a = 16'h3C96;
    // Word from test_basic still waiting; ready stays low for five cycles.
    for (int i = 0; i < 5; i++) begin
      start_a = (i == 2);
      cyc();
      if (valid_a !== 1'b1 || word_a !== 16'hA5C3 || busy_a !== 1'b0) hold_err++;
    end
    start_a = 1'b0;
    n_checks++; if (hold_err !== 0) $display("FAIL b2b_hold: %0d bad cycles, need 0", hold_err); else n_pass++;
    ready_a = 1'b1; start_a = 1'b1; cyc(); ready_a = 1'b0; start_a = 1'b0;
    n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b1 || en_n_a !== 1'b0)
      $display("FAIL b2b_restart: valid=%b busy=%b en_n=%b need 0 1 0", valid_a, busy_a, en_n_a); else n_pass++;
    run_a("b2b", 16'h3C96);
    ready_a = 1'b1; cyc(); ready_a = 1'b0;
    n_checks++; if (valid_a !== 1'b0 || word_a !== 16'h3C96 || busy_a !== 1'b0)
      $display("FAIL b2b_consume: valid=%b word=%h busy=%b need 0 3c96 0", valid_a, word_a, busy_a); else n_pass++;
  endtask

  task automatic test_abort();
    int k;
    pat_a = 16'h5AF0;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    k = 0;
    while (sel_a !== 4'd7 && k < 50) begin cyc(); k++; end
    n_checks++; if (k !== 7) $display("FAIL abort_reach_sel7: took %0d cycles, need 7", k); else n_pass++;
    abort_a = 1'b1; start_a = 1'b1; cyc(); abort_a = 1'b0; start_a = 1'b0;
    n_checks++; if (busy_a !== 1'b0 || en_n_a !== 1'b1 || sel_a !== 4'd0)
      $display("FAIL abort_idle: busy=%b en_n=%b sel=%0d need 0 1 0", busy_a, en_n_a, sel_a); else n_pass++;
    repeat (3) cyc();
    n_checks++; if (valid_a !== 1'b0 || word_a !== 16'h3C96 || busy_a !== 1'b0)
      $display("FAIL abort_no_word: valid=%b word=%h busy=%b need 0 3c96 0", valid_a, word_a, busy_a); else n_pass++;
    pat_a = 16'h0F0F;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_a("after_abort", 16'h0F0F);
    ready_a = 1'b1; cyc(); ready_a = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int seq_err;
    seq_err = 0;
    pat_a = 16'hBEEF;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    // A start pulse at sel 3 must not restart the walk.
    for (int k = 0; k < 9; k++) begin
      if (sel_a !== 4'(k)) seq_err++;
      start_a = (k == 3);
      cyc();
    end
    start_a = 1'b0;
    n_checks++; if (seq_err !== 0 || sel_a !== 4'd9) $display("FAIL ignore_start: %0d bad cycles, sel=%0d need 0 and 9", seq_err, sel_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sel_a !== 4'd0 || en_n_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0 || word_a !== 16'h0)
      $display("FAIL async_reset: sel=%0d en_n=%b busy=%b valid=%b word=%h need 0 1 0 0 0000",
               sel_a, en_n_a, busy_a, valid_a, word_a); else n_pass++;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL reset_no_partial: valid=%b busy=%b need 0 0", valid_a, busy_a); else n_pass++;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_a("after_reset", 16'hBEEF);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle();
    test_invert();
    test_back_to_back();
    test_abort();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
